draw_sequencer: RTL and testbench
=================================

# draw_sequencer

Control FSM that sequences `drawCircuit_datapath` through one full redraw of the command list: reset its data, then per command read, RAM settle, draw, clear, until the datapath reports `finished_all`. Sits between the top-level redraw trigger and the datapath. Owns every `go_*` handshake and reports busy, done, the completed-command count and an optional watchdog error.

## Interface
Parameters:
- `RAM_WAIT`, 2: settle cycles between `command_read` and `go_draw_command` (processor RAM read latency); legal 1..15.
- `WD_LIMIT`, 2500000: watchdog limit in cycles spent in DRAW; 22-bit.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  redraw request; sampled only in IDLE.
- `go_reset_data`  out  1  to datapath.
- `data_reset_done`  in  1  from datapath.
- `go_read_processor`  out  1  to datapath.
- `command_read`  in  1  from datapath.
- `finished_all`  in  1  from datapath.
- `go_draw_command`  out  1  to datapath.
- `done_draw_command`  in  1  from datapath.
- `go_clear_signal`  out  1  to datapath.
- `signals_cleared`  in  1  from datapath.
- `busy`  out  1  high in every state except IDLE.
- `frame_done`  out  1  one-cycle pulse when a redraw completes.
- `cmd_count`  out  10  commands completed in the current or last redraw.
- `wd_error`  out  1  sticky watchdog flag (0 when macro off).

## Operation
- States: IDLE, RST, READ, SETTLE, DRAW, CLEAR, DONE.
- Moore outputs: `go_reset_data`=RST, `go_read_processor`=READ, `go_draw_command`=DRAW, `go_clear_signal`=CLEAR. At most one `go_*` is high in any cycle.
- IDLE: if `start`, go to RST, clear `cmd_count` and `wd_error`. While busy, `start` is ignored and not queued.
- RST: on `data_reset_done`, go to READ.
- READ: `finished_all` has priority: go to DONE. Otherwise on `command_read`, go to SETTLE and load the settle counter with `RAM_WAIT`-1.
- SETTLE: decrement the settle counter. When it is 0, go to DRAW.
- DRAW: on `done_draw_command`, go to CLEAR. The watchdog counter clears on DRAW entry.
- CLEAR: on `signals_cleared`, go to READ and increment `cmd_count`. The count saturates at 1023.
- DONE: `frame_done`=1 for one cycle, then go to IDLE. `cmd_count` holds until the next `start`.
- Acks are sampled every cycle while in the state that waits for them. Acks seen in any other state are ignored.

## Timing
- Reset value: state IDLE; all outputs 0; settle and watchdog counters 0.
- Reset mid-operation: next cycle is IDLE with all `go_*` low. The datapath is not touched. The next `start` re-enters RST, which restores it.
- Each `go_*` rises one cycle after entering its state. It stays high until the ack is sampled and drops the cycle after that, so minimum width is 2 cycles.
- `start` to `go_reset_data` high: 1 cycle.
- `command_read` to `go_draw_command`: `RAM_WAIT`+1 cycles.
- Minimum per-command overhead outside DRAW: READ 2 + SETTLE `RAM_WAIT` + CLEAR 2 cycles.
- Empty list (`finished_all` on the first read): IDLE→RST→READ→DONE, `cmd_count`=0, one `frame_done`.

## Configuration
- `DRAW_SEQ_WATCHDOG_EN` defined:
  - The 22-bit counter runs in DRAW.
  - When the counter equals `WD_LIMIT` with no `done_draw_command`, go to CLEAR, set `wd_error`=1 (sticky until next `start`) and still count the command.
  - `done_draw_command` in the same cycle as the limit wins, and `wd_error` is not set.
- Undefined: no counter logic; `wd_error` is tied to 0; DRAW waits indefinitely.

## Structure
- Package `draw_seq_pkg`: state enum (3-bit `draw_seq_state_t`), `CMD_CNT_W`=10, `WD_W`=22.
- One sub-module, `draw_seq_timer`: a loadable down/up counter with zero/limit compare. It is instantiated for the settle counter and, when enabled, the watchdog.

## Test plan
- Reset then `start` against a datapath model with 3 commands, `RAM_WAIT`=2 → `frame_done` once, `cmd_count`=3, `go_draw_command` rises exactly 3 cycles after each `command_read`.
- `finished_all` on the first READ → DONE within 5 cycles of `start`, `cmd_count`=0, no `go_draw_command` ever.
- `start` pulsed while in DRAW → ignored; after completion the FSM is IDLE and issues no second RST.
- `reset` asserted while `go_draw_command` is high → next cycle all outputs 0, state IDLE; a fresh `start` completes normally.
- Watchdog on, `WD_LIMIT`=100, model never acks draw → CLEAR entered after 100 DRAW cycles, `wd_error`=1, sequence continues to `frame_done`.
- Watchdog on, `done_draw_command` in the same cycle as the limit → `wd_error` stays 0.

Source files
------------

// File: rtl/draw_seq_pkg.sv
// Shared types and widths for the draw sequencer: FSM state encoding,
// counter widths and the saturating command-count increment.
package draw_seq_pkg;

  localparam int CMD_CNT_W = 10;
  localparam int WD_W      = 22;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RST    = 3'd1,
    ST_READ   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_DRAW   = 3'd4,
    ST_CLEAR  = 3'd5,
    ST_DONE   = 3'd6
  } draw_seq_state_t;

  localparam logic [CMD_CNT_W-1:0] CMD_CNT_MAX = {CMD_CNT_W{1'b1}};
  localparam logic [CMD_CNT_W-1:0] CMD_CNT_ONE = {{(CMD_CNT_W-1){1'b0}}, 1'b1};

  // The count sticks at all-ones so a very long list never wraps back to a small value.
  function automatic logic [CMD_CNT_W-1:0] sat_inc_cnt(input logic [CMD_CNT_W-1:0] i_val);
    logic [CMD_CNT_W-1:0] w_res;
    if (i_val == CMD_CNT_MAX) begin
      w_res = i_val;
    end else begin
      w_res = i_val + CMD_CNT_ONE;
    end
    return w_res;
  endfunction

endpackage

// File: rtl/draw_seq_timer.sv
// Loadable counter used by the draw sequencer. UP=0: down counter with a
// zero compare (settle delay). UP=1: up counter with a next-value limit compare (watchdog).
module draw_seq_timer
  import draw_seq_pkg::*;
#(
  parameter int W  = 4,
  parameter bit UP = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clear,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_step,
  input  logic [W-1:0] i_limit,
  output logic         o_hit
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] r_count;
  logic [W-1:0] w_step_val;

  assign w_step_val = UP ? (r_count + ONE) : (r_count - ONE);

  // Up mode flags the step that will reach the limit, so the caller can leave on that same edge.
  assign o_hit = UP ? (w_step_val == i_limit) : (r_count == {W{1'b0}});

  // Counter register: clear beats load, load beats step.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= {W{1'b0}};
    end else if (i_clear) begin
      r_count <= {W{1'b0}};
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_step) begin
      r_count <= w_step_val;
    end
  end

endmodule

// File: rtl/draw_sequencer.sv
// Control FSM that walks drawCircuit_datapath through one full redraw of the
// command list. Optional DRAW watchdog is built when DRAW_SEQ_WATCHDOG_EN is defined.
module draw_sequencer
  import draw_seq_pkg::*;
#(
  parameter int RAM_WAIT = 2,
  parameter int WD_LIMIT = 2500000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 go_reset_data,
  input  logic                 data_reset_done,
  output logic                 go_read_processor,
  input  logic                 command_read,
  input  logic                 finished_all,
  output logic                 go_draw_command,
  input  logic                 done_draw_command,
  output logic                 go_clear_signal,
  input  logic                 signals_cleared,
  output logic                 busy,
  output logic                 frame_done,
  output logic [CMD_CNT_W-1:0] cmd_count,
  output logic                 wd_error
);

  localparam logic [3:0] SETTLE_LOAD = 4'(RAM_WAIT - 1);

  if (RAM_WAIT < 1 || RAM_WAIT > 15 || WD_LIMIT < 1 || WD_LIMIT > 4194303) begin : g_bad_param
    $error("draw_sequencer: RAM_WAIT or WD_LIMIT out of range");
  end

  draw_seq_state_t      r_state;
  logic                 r_go_reset_data;
  logic                 r_go_read_processor;
  logic                 r_go_draw_command;
  logic                 r_go_clear_signal;
  logic                 r_busy;
  logic                 r_frame_done;
  logic [CMD_CNT_W-1:0] r_cmd_count;
  logic                 r_wd_error;

  logic w_settle_load;
  logic w_settle_step;
  logic w_settle_zero;
  logic w_wd_hit;

  assign w_settle_load = (r_state == ST_READ) && !finished_all && command_read;
  assign w_settle_step = (r_state == ST_SETTLE) && !w_settle_zero;

  draw_seq_timer #(
    .W  (4),
    .UP (1'b0)
  ) u_settle (
    .clk        (clk),
    .reset      (reset),
    .i_clear    (1'b0),
    .i_load     (w_settle_load),
    .i_load_val (SETTLE_LOAD),
    .i_step     (w_settle_step),
    .i_limit    (4'd0),
    .o_hit      (w_settle_zero)
  );

`ifdef DRAW_SEQ_WATCHDOG_EN
  localparam logic [WD_W-1:0] WD_LIMIT_C = WD_W'(WD_LIMIT);

  logic w_wd_in_draw;
  logic w_wd_limit_next;

  assign w_wd_in_draw = (r_state == ST_DRAW);

  // Held at zero outside DRAW, so every DRAW visit starts a fresh count.
  draw_seq_timer #(
    .W  (WD_W),
    .UP (1'b1)
  ) u_watchdog (
    .clk        (clk),
    .reset      (reset),
    .i_clear    (!w_wd_in_draw),
    .i_load     (1'b0),
    .i_load_val ({WD_W{1'b0}}),
    .i_step     (w_wd_in_draw),
    .i_limit    (WD_LIMIT_C),
    .o_hit      (w_wd_limit_next)
  );

  assign w_wd_hit = w_wd_in_draw && w_wd_limit_next;
`else
  assign w_wd_hit = 1'b0;
`endif

  // Sequencer state, Moore go_* outputs (one cycle behind the state) and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state             <= ST_IDLE;
      r_go_reset_data     <= 1'b0;
      r_go_read_processor <= 1'b0;
      r_go_draw_command   <= 1'b0;
      r_go_clear_signal   <= 1'b0;
      r_busy              <= 1'b0;
      r_frame_done        <= 1'b0;
      r_cmd_count         <= {CMD_CNT_W{1'b0}};
      r_wd_error          <= 1'b0;
    end else begin
      r_go_reset_data     <= (r_state == ST_RST);
      r_go_read_processor <= (r_state == ST_READ);
      r_go_draw_command   <= (r_state == ST_DRAW);
      r_go_clear_signal   <= (r_state == ST_CLEAR);
      r_frame_done        <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state     <= ST_RST;
            r_busy      <= 1'b1;
            r_cmd_count <= {CMD_CNT_W{1'b0}};
            r_wd_error  <= 1'b0;
          end
        end
        ST_RST: begin
          if (data_reset_done) begin
            r_state <= ST_READ;
          end
        end
        ST_READ: begin
          if (finished_all) begin
            r_state      <= ST_DONE;
            r_frame_done <= 1'b1;
          end else if (command_read) begin
            r_state <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (w_settle_zero) begin
            r_state <= ST_DRAW;
          end
        end
        ST_DRAW: begin
          // A real completion in the limit cycle wins over the watchdog.
          if (done_draw_command) begin
            r_state <= ST_CLEAR;
          end else if (w_wd_hit) begin
            r_state    <= ST_CLEAR;
            r_wd_error <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (signals_cleared) begin
            r_state     <= ST_READ;
            r_cmd_count <= sat_inc_cnt(r_cmd_count);
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign go_reset_data     = r_go_reset_data;
  assign go_read_processor = r_go_read_processor;
  assign go_draw_command   = r_go_draw_command;
  assign go_clear_signal   = r_go_clear_signal;
  assign busy              = r_busy;
  assign frame_done        = r_frame_done;
  assign cmd_count         = r_cmd_count;
  assign wd_error          = r_wd_error;

endmodule

// File: tb/tb_draw_sequencer.sv
// Directed bench for draw_sequencer with a small datapath model that acks
// each go_* one half-cycle after it rises; watchdog cases need DRAW_SEQ_WATCHDOG_EN.
module tb_draw_sequencer;

  localparam int RAM_WAIT = 2;
  localparam int WD_LIMIT = 100;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       data_reset_done = 1'b0;
  logic       command_read = 1'b0;
  logic       finished_all = 1'b0;
  logic       done_draw_command = 1'b0;
  logic       signals_cleared = 1'b0;
  logic       go_reset_data, go_read_processor, go_draw_command, go_clear_signal;
  logic       busy, frame_done, wd_error;
  logic [9:0] cmd_count;

  draw_sequencer #(.RAM_WAIT(RAM_WAIT), .WD_LIMIT(WD_LIMIT)) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .go_reset_data     (go_reset_data),
    .data_reset_done   (data_reset_done),
    .go_read_processor (go_read_processor),
    .command_read      (command_read),
    .finished_all      (finished_all),
    .go_draw_command   (go_draw_command),
    .done_draw_command (done_draw_command),
    .go_clear_signal   (go_clear_signal),
    .signals_cleared   (signals_cleared),
    .busy              (busy),
    .frame_done        (frame_done),
    .cmd_count         (cmd_count),
    .wd_error          (wd_error)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Model and monitor state
  int   n_cmds = 0, model_idx = 0, draw_mode = 0;
  int   draw_w = 0, last_draw_w = 0, cr_edge = 0;
  int   n_draw_rise = 0, n_reset_rise = 0, n_frame = 0, frame_edge = 0, n_multi_go = 0;
  int   start_edge = 0;
  int   lat_q[$];
  logic p_go_draw = 1'b0, p_go_clear = 1'b0, p_go_reset = 1'b0, p_cr = 1'b0;

  // Datapath model: responds on the falling edge to what the DUT drove on the rising edge.
  always @(negedge clk) begin
    if (go_draw_command && !p_go_draw) begin
      n_draw_rise++;
      lat_q.push_back(cyc - cr_edge);
    end
    if (p_go_draw && !go_draw_command) last_draw_w = draw_w;
    draw_w = go_draw_command ? draw_w + 1 : 0;
    if (go_reset_data && !p_go_reset) n_reset_rise++;
    if (frame_done) begin
      n_frame++;
      frame_edge = cyc;
    end
    if (int'(go_reset_data) + int'(go_read_processor) + int'(go_draw_command)
        + int'(go_clear_signal) > 1) n_multi_go++;
    if (go_reset_data) model_idx = 0;
    if (go_clear_signal && !p_go_clear) model_idx++;
    data_reset_done = go_reset_data;
    finished_all    = go_read_processor && (model_idx >= n_cmds);
    command_read    = go_read_processor && (model_idx < n_cmds);
    if (command_read && !p_cr) cr_edge = cyc + 1;
    case (draw_mode)
      0:       done_draw_command = go_draw_command;
      1:       done_draw_command = 1'b0;
      default: done_draw_command = go_draw_command && (draw_w == WD_LIMIT - 1);
    endcase
    signals_cleared = go_clear_signal;
    p_go_draw  = go_draw_command;
    p_go_clear = go_clear_signal;
    p_go_reset = go_reset_data;
    p_cr       = command_read;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic start_frame(input int ncmd, input int mode);
    n_cmds = ncmd;
    draw_mode = mode;
    n_frame = 0;
    n_draw_rise = 0;
    n_reset_rise = 0;
    lat_q.delete();
    start_edge = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_frame(input string tag, input int budget);
    for (int i = 0; i < budget && n_frame == 0; i++) tick();
    check_val(tag, 32'(n_frame > 0), 32'd1);
    repeat (5) tick();
  endtask

  task automatic wait_draw_rise(input string tag, input int nth, input int budget);
    for (int i = 0; i < budget && !(go_draw_command && n_draw_rise == nth); i++) tick();
    check_val(tag, 32'(go_draw_command && n_draw_rise == nth), 32'd1);
  endtask

  initial begin
    repeat (3) tick();
    check_val("reset_outs", 32'({go_reset_data, go_read_processor, go_draw_command,
                                 go_clear_signal, busy, frame_done, wd_error}), 32'd0);
    check_val("reset_cnt", 32'(cmd_count), 32'd0);
    reset = 1'b0;
    tick();

    // Three commands: each command_read-to-go_draw is RAM_WAIT+1 sampling edges.
    start_frame(3, 0);
    check_val("busy_after_start", 32'(busy), 32'd1);
    wait_frame("frame3_timeout", 500);
    check_val("frame3_pulses", 32'(n_frame), 32'd1);
    check_val("frame3_count", 32'(cmd_count), 32'd3);
    check_val("frame3_draws", 32'(lat_q.size()), 32'd3);
    for (int i = 0; i < lat_q.size(); i++) check_val("draw_latency", 32'(lat_q[i]), 32'd3);
    check_val("frame3_idle", 32'(busy), 32'd0);
    check_val("frame3_wd", 32'(wd_error), 32'd0);

    // Empty list: IDLE->RST->READ->DONE, frame_done 5 edges after start is sampled-from.
    start_frame(0, 0);
    wait_frame("empty_timeout", 50);
    check_val("empty_latency", 32'(frame_edge - start_edge), 32'd5);
    check_val("empty_pulses", 32'(n_frame), 32'd1);
    check_val("empty_count", 32'(cmd_count), 32'd0);
    check_val("empty_no_draw", 32'(n_draw_rise), 32'd0);

    // start pulsed while drawing must not queue a second redraw.
    start_frame(2, 0);
    wait_draw_rise("busy_start_wait", 1, 200);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_frame("busy_start_timeout", 500);
    repeat (10) tick();
    check_val("busy_start_rst_once", 32'(n_reset_rise), 32'd1);
    check_val("busy_start_frames", 32'(n_frame), 32'd1);
    check_val("busy_start_count", 32'(cmd_count), 32'd2);
    check_val("busy_start_idle", 32'(busy), 32'd0);

    // reset while go_draw_command is high on the second command.
    start_frame(3, 0);
    wait_draw_rise("midrst_wait", 2, 300);
    check_val("midrst_count_before", 32'(cmd_count), 32'd1);
    reset = 1'b1;
    tick();
    check_val("midrst_outs", 32'({go_reset_data, go_read_processor, go_draw_command,
                                  go_clear_signal, busy, frame_done, wd_error}), 32'd0);
    check_val("midrst_count", 32'(cmd_count), 32'd0);
    reset = 1'b0;
    repeat (3) tick();
    check_val("midrst_stay_idle", 32'({go_reset_data, busy}), 32'd0);
    start_frame(3, 0);
    wait_frame("midrst_restart_timeout", 500);
    check_val("midrst_restart_count", 32'(cmd_count), 32'd3);
    check_val("midrst_restart_frames", 32'(n_frame), 32'd1);

    // Count saturates at 1023.
    start_frame(1025, 0);
    wait_frame("sat_timeout", 20000);
    check_val("sat_count", 32'(cmd_count), 32'd1023);

`ifdef DRAW_SEQ_WATCHDOG_EN
    // Draw never acked: watchdog forces CLEAR after WD_LIMIT cycles and the command still counts.
    start_frame(1, 1);
    wait_frame("wd_timeout_frame", 1000);
    check_val("wd_draw_width", 32'(last_draw_w), 32'(WD_LIMIT));
    check_val("wd_error_set", 32'(wd_error), 32'd1);
    check_val("wd_count", 32'(cmd_count), 32'd1);
    // Ack in the limit cycle beats the watchdog; start also clears the old error.
    start_frame(1, 2);
    check_val("wd_cleared_by_start", 32'(wd_error), 32'd0);
    wait_frame("wd_race_frame", 1000);
    check_val("wd_race_width", 32'(last_draw_w), 32'(WD_LIMIT));
    check_val("wd_race_no_error", 32'(wd_error), 32'd0);
    check_val("wd_race_count", 32'(cmd_count), 32'd1);
`else
    check_val("wd_tied_low", 32'(wd_error), 32'd0);
`endif

    check_val("go_onehot", 32'(n_multi_go), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
